rect_draw_scheduler: RTL and testbench
======================================

Name: rect_draw_scheduler

Overview:
- Shares the single VGA framebuffer plot port among NUM_REQ requesters: mole sprites, hammer cursor, background clear and score box.
- Each requester asks for a solid-colour rectangle fill.
- The block grants one requester at a time in round-robin order, then sweeps the pixel x/y raster over that rectangle.
- It emits one plot per cycle and clips anything outside the 160x120 screen.

Parameters:
- NUM_REQ, 4, number of requesters.
- X_W, 8, x coordinate and width bits.
- Y_W, 7, y coordinate and height bits.
- COLOUR_W, 3, colour bits.
- SCREEN_W, 160, visible columns; valid x is 0..159.
- SCREEN_H, 120, visible rows; valid y is 0..119.

Ports:
- clock  in  1  system clock.
- resetn  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  level request, one bit per requester.
- req_x0  in  NUM_REQ*X_W  top-left x per requester, packed with requester i at bits [i*X_W +: X_W].
- req_y0  in  NUM_REQ*Y_W  top-left y per requester, packed the same way.
- req_w  in  NUM_REQ*X_W  width in pixels per requester.
- req_h  in  NUM_REQ*Y_W  height in pixels per requester.
- req_colour  in  NUM_REQ*COLOUR_W  fill colour per requester.
- ack  out  NUM_REQ  one-cycle pulse: request accepted and geometry latched.
- busy  out  1  high when the block is not in IDLE.
- plot  out  1  framebuffer write enable.
- x  out  X_W  pixel column.
- y  out  Y_W  pixel row.
- colour  out  COLOUR_W  pixel colour.
- done  out  1  one-cycle pulse: rectangle complete.
- done_id  out  clog2(NUM_REQ)  index of the requester whose rectangle just completed.

Behaviour:
- Reset (async): state=IDLE; ack=0, plot=0, done=0, busy=0; x=0, y=0, colour=0, done_id=0; round-robin pointer set so requester 0 has highest priority.
- States: IDLE, DRAW, FINISH.
- IDLE, any req high:
  - Winner = first requester with req high, searching from (last_winner+1) mod NUM_REQ upward.
  - At the next edge: latch the winner's x0, y0, w, h, colour and id; ack[winner]=1 for exactly one cycle; set cx=0, cy=0; update last_winner.
  - Next state = DRAW, or FINISH if w==0 or h==0.
- IDLE, no req: stay in IDLE with all outputs inactive.
- DRAW, per cycle:
  - Outputs are driven combinationally from registers: x=x0+cx, y=y0+cy, colour=latched colour.
  - plot=1 only if (x0+cx)<SCREEN_W and (y0+cy)<SCREEN_H. Both sums are computed one bit wider to avoid wrap.
  - Clipped pixels still consume their cycle with plot=0, so DRAW always lasts exactly w*h cycles.
- Raster order, row-major: cx runs 0..w-1; at cx==w-1, cx returns to 0 and cy increments.
- Leaving DRAW: at cx==w-1 and cy==h-1 the next state is FINISH.
- FINISH: done=1 and done_id=latched id for one cycle, plot=0; next state IDLE.
- Latency:
  - req sampled in IDLE at edge N.
  - ack high during cycle N+1, which is also the first DRAW cycle.
  - Last pixel at cycle N+w*h.
  - done at cycle N+w*h+1.
  - Earliest next grant is sampled at edge N+w*h+2.
- Requester rules:
  - Hold req and geometry stable until ack is seen.
  - Geometry changes after ack are ignored.
  - req still high after done is treated as a new request.
- req changes while DRAW or FINISH are ignored; there is no preemption.
- Simultaneous requests: only one is granted per arbitration; the others wait. Pointer rotation guarantees every continuously requesting requester is served within NUM_REQ grants.
- Reset mid-DRAW: the rectangle is abandoned immediately, with no done pulse and plot forced to 0.

Decomposition:
- Shared package holds:
  - SCREEN_W and SCREEN_H constants.
  - X_W, Y_W and COLOUR_W constants.
  - State enum: IDLE, DRAW, FINISH.
  - A rect descriptor typedef: x0, y0, w, h, colour.
- One sub-module, rr_arbiter:
  - Inputs: req vector, and an update enable that advances the rotating pointer on a grant.
  - Outputs: one-hot grant and the winner index.
  - Purely combinational select plus the pointer register.

Test Plan:
- Single req[1]: x0=10, y0=5, w=2, h=2, colour=3.
  - Response: ack[1] for one cycle; plot on 4 consecutive cycles at (10,5), (11,5), (10,6), (11,6), colour=3; then done=1 with done_id=1; busy low the cycle after.
- req[0] and req[2] rise together after reset, each 1x1.
  - Response: requester 0 is served (ack, one plot, done_id=0) before requester 2 (done_id=2).
- All 4 requesters hold req high continuously with 1x1 rectangles.
  - Response: grant order is 0,1,2,3,0,1; each done pulse is 3 cycles apart.
- Clipping, x0=158, y0=119, w=4, h=2.
  - Response: exactly 8 DRAW cycles; plot=1 only at (158,119) and (159,119).
- w=0, h=5.
  - Response: ack, then done on the next cycle, with no plot at any point.
- Reset mid-draw: assert resetn=0 during pixel 3 of a 4x4 rectangle.
  - Response: plot=0 and busy=0 immediately; no done pulse.
  - A request raised after reset release is granted to requester 0 first.

Source files
------------

// File: rtl/rect_draw_scheduler_pkg.sv
// rtl/rect_draw_scheduler_pkg.sv - shared constants, state codes and rectangle descriptor
package rect_draw_scheduler_pkg;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DRAW   = 2'd1;
  localparam state_t ST_FINISH = 2'd2;

  typedef struct packed {
    logic [X_W-1:0]      x0;
    logic [Y_W-1:0]      y0;
    logic [X_W-1:0]      w;
    logic [Y_W-1:0]      h;
    logic [COLOUR_W-1:0] colour;
  } rect_t;

endpackage

// File: rtl/rect_draw_scheduler_if.sv
// rtl/rect_draw_scheduler_if.sv - requester and framebuffer plot signals of the scheduler
interface rect_draw_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  import rect_draw_scheduler_pkg::*;

  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*X_W-1:0]      req_x0;
  logic [NUM_REQ*Y_W-1:0]      req_y0;
  logic [NUM_REQ*X_W-1:0]      req_w;
  logic [NUM_REQ*Y_W-1:0]      req_h;
  logic [NUM_REQ*COLOUR_W-1:0] req_colour;
  logic [NUM_REQ-1:0]          ack;
  logic                        busy;
  logic                        plot;
  logic [X_W-1:0]              x;
  logic [Y_W-1:0]              y;
  logic [COLOUR_W-1:0]         colour;
  logic                        done;
  logic [ID_W-1:0]             done_id;

  modport master (
    output req, req_x0, req_y0, req_w, req_h, req_colour,
    input  ack, busy, plot, x, y, colour, done, done_id
  );

  modport slave (
    input  req, req_x0, req_y0, req_w, req_h, req_colour,
    output ack, busy, plot, x, y, colour, done, done_id
  );

endinterface

// File: rtl/rect_draw_scheduler_rr_arbiter.sv
// rtl/rect_draw_scheduler_rr_arbiter.sv - round-robin arbiter with rotating priority pointer
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    winner
);

  logic [ID_W-1:0] last_winner;
  logic [ID_W-1:0] idx;
  logic            found;

  // Search upward from the requester after the last winner, wrapping once.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((int'(last_winner) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    grant = found ? (NUM_REQ'(1) << winner) : '0;
  end

  // Pointer starts at the top index so requester 0 has priority after reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last_winner <= ID_W'(NUM_REQ - 1);
    end else if (update && found) begin
      last_winner <= winner;
    end
  end

endmodule

// File: rtl/rect_draw_scheduler.sv
// rtl/rect_draw_scheduler.sv - arbitrates rectangle fills and rasters them onto the plot port
module rect_draw_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input logic                  clock,
  input logic                  resetn,
  rect_draw_scheduler_if.slave bus
);
  import rect_draw_scheduler_pkg::*;

  localparam logic [X_W:0] X_LIM = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0] Y_LIM = (Y_W + 1)'(SCREEN_H);

  state_t             state;
  rect_t              rect;
  rect_t              pick;
  logic [ID_W-1:0]    id;
  logic [X_W-1:0]     cx;
  logic [Y_W-1:0]     cy;
  logic [NUM_REQ-1:0] ack_r;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    winner;
  logic               arb_en;
  logic               drawing;
  logic               last_col;
  logic               last_row;
  logic [X_W:0]       sum_x;
  logic [Y_W:0]       sum_y;

  assign arb_en = (state == ST_IDLE) && (|bus.req);

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clock  (clock),
    .resetn (resetn),
    .req    (bus.req),
    .update (arb_en),
    .grant  (grant),
    .winner (winner)
  );

  // Slice the winning requester's geometry out of the packed request buses.
  always_comb begin
    pick.x0     = bus.req_x0[int'(winner) * X_W +: X_W];
    pick.y0     = bus.req_y0[int'(winner) * Y_W +: Y_W];
    pick.w      = bus.req_w[int'(winner) * X_W +: X_W];
    pick.h      = bus.req_h[int'(winner) * Y_W +: Y_W];
    pick.colour = bus.req_colour[int'(winner) * COLOUR_W +: COLOUR_W];
  end

  // Pixel coordinates are one bit wider so off-screen positions never wrap back on.
  always_comb begin
    sum_x    = {1'b0, rect.x0} + {1'b0, cx};
    sum_y    = {1'b0, rect.y0} + {1'b0, cy};
    last_col = (cx == rect.w - 1'b1);
    last_row = (cy == rect.h - 1'b1);
    drawing  = (state == ST_DRAW);
  end

  // Grant in IDLE, sweep the raster row-major in DRAW, pulse done from FINISH.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      rect  <= '0;
      id    <= '0;
      cx    <= '0;
      cy    <= '0;
      ack_r <= '0;
    end else begin
      ack_r <= '0;
      case (state)
        ST_IDLE: begin
          if (arb_en) begin
            rect  <= pick;
            id    <= winner;
            ack_r <= grant;
            cx    <= '0;
            cy    <= '0;
            state <= (pick.w == '0 || pick.h == '0) ? ST_FINISH : ST_DRAW;
          end
        end
        ST_DRAW: begin
          if (last_col) begin
            cx <= '0;
            if (last_row) begin
              state <= ST_FINISH;
            end else begin
              cy <= cy + 1'b1;
            end
          end else begin
            cx <= cx + 1'b1;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so a reset clears them without waiting for a clock.
  always_comb begin
    bus.ack     = ack_r;
    bus.busy    = (state != ST_IDLE);
    bus.plot    = drawing && (sum_x < X_LIM) && (sum_y < Y_LIM);
    bus.x       = drawing ? sum_x[X_W-1:0] : '0;
    bus.y       = drawing ? sum_y[Y_W-1:0] : '0;
    bus.colour  = drawing ? rect.colour : '0;
    bus.done    = (state == ST_FINISH);
    bus.done_id = (state == ST_FINISH) ? id : '0;
  end

endmodule

// File: tb/tb_rect_draw_scheduler.sv
// tb/tb_rect_draw_scheduler.sv - self-checking bench for rect_draw_scheduler
module tb_rect_draw_scheduler;
  import rect_draw_scheduler_pkg::*;

  localparam int N = 4;

  typedef struct packed {
    logic [N-1:0]        ack;
    logic                busy;
    logic                plot;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                done;
    logic [1:0]          done_id;
  } out_t;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] c;
  } pix_t;

  logic clock  = 1'b0;
  logic resetn = 1'b1;
  always #5 clock = ~clock;

  rect_draw_scheduler_if #(.NUM_REQ(N)) bus();

  rect_draw_scheduler #(.NUM_REQ(N)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  out_t     mq[$];
  int       ptr = N - 1;
  int       cyc = 0;
  logic [N-1:0] ack_prev = '0;
  pix_t     plot_log[$];
  int       done_id_log[$];
  int       done_cyc_log[$];
  int       ack_cyc_log[$];
  bit       busy_log[$];
  int       draw_cnt = 0;
  int       n_checks = 0;
  int       n_fail = 0;
  bit       auto_drop = 1'b1;
  bit       rand_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Transaction-level model: pick winner by rotation, then list every output cycle of the fill.
  task automatic model_grant();
    int   win;
    int   x0, y0, w, h, col, sx, sy;
    out_t o;
    win = -1;
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (ptr + i) % N;
      if (win < 0 && bus.req[k[1:0]]) win = k;
    end
    x0  = int'(bus.req_x0[win*X_W +: X_W]);
    y0  = int'(bus.req_y0[win*Y_W +: Y_W]);
    w   = int'(bus.req_w[win*X_W +: X_W]);
    h   = int'(bus.req_h[win*Y_W +: Y_W]);
    col = int'(bus.req_colour[win*COLOUR_W +: COLOUR_W]);
    ptr = win;
    if (w != 0 && h != 0) begin
      for (int r = 0; r < h; r++) begin
        for (int c = 0; c < w; c++) begin
          o        = '0;
          o.ack    = (r == 0 && c == 0) ? (N'(1) << win) : '0;
          o.busy   = 1'b1;
          sx       = x0 + c;
          sy       = y0 + r;
          o.plot   = (sx < SCREEN_W) && (sy < SCREEN_H);
          o.x      = X_W'(sx);
          o.y      = Y_W'(sy);
          o.colour = COLOUR_W'(col);
          mq.push_back(o);
        end
      end
    end
    o         = '0;
    o.ack     = (w == 0 || h == 0) ? (N'(1) << win) : '0;
    o.busy    = 1'b1;
    o.done    = 1'b1;
    o.done_id = 2'(win);
    mq.push_back(o);
  endtask

  // Every cycle: compare all outputs with the model and log observed events.
  always @(negedge clock) begin
    out_t act_o, exp_o;
    cyc++;
    act_o = {bus.ack, bus.busy, bus.plot, bus.x, bus.y, bus.colour, bus.done, bus.done_id};
    ack_prev = bus.ack;
    if (!resetn) begin
      mq.delete();
      ptr   = N - 1;
      exp_o = '0;
    end else if (mq.size() == 0) begin
      exp_o = '0;
      if (|bus.req) model_grant();
    end else begin
      exp_o = mq.pop_front();
    end
    check("outputs", 32'(act_o), 32'(exp_o));
    if (act_o.plot) plot_log.push_back(pix_t'({act_o.x, act_o.y, act_o.colour}));
    if (act_o.done) begin
      done_id_log.push_back(int'(act_o.done_id));
      done_cyc_log.push_back(cyc);
    end
    if (|act_o.ack) ack_cyc_log.push_back(cyc);
    if (act_o.busy && !act_o.done) draw_cnt++;
    busy_log.push_back(act_o.busy);
  end

  task automatic set_rect(input int i, input int x0, input int y0, input int w, input int h, input int col);
    bus.req_x0[i*X_W +: X_W]             = X_W'(x0);
    bus.req_y0[i*Y_W +: Y_W]             = Y_W'(y0);
    bus.req_w[i*X_W +: X_W]              = X_W'(w);
    bus.req_h[i*Y_W +: Y_W]              = Y_W'(h);
    bus.req_colour[i*COLOUR_W +: COLOUR_W] = COLOUR_W'(col);
    bus.req[i]                           = 1'b1;
  endtask

  task automatic rand_geom(input int i);
    int x0, y0;
    x0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(150, 255)) : int'($urandom_range(0, 159));
    y0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(110, 127)) : int'($urandom_range(0, 119));
    set_rect(i, x0, y0, int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), int'($urandom_range(0, 7)));
    bus.req[i] = 1'b0;
  endtask

  task automatic rand_step();
    resetn = ($urandom_range(0, 499) != 0);
    for (int i = 0; i < N; i++) begin
      if (ack_prev[i]) begin
        logic keep;
        keep = ($urandom_range(0, 3) == 0);
        rand_geom(i);
        bus.req[i] = keep;
      end else if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
        rand_geom(i);
        bus.req[i] = 1'b1;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      if (auto_drop) bus.req = bus.req & ~ack_prev;
      if (rand_en) rand_step();
    end
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    resetn  = 1'b0;
    bus.req = '0;
    tick(2);
    resetn = 1'b1;
  endtask

  initial begin
    int pb, db, ab, dc;
    bus.req        = '0;
    bus.req_x0     = '0;
    bus.req_y0     = '0;
    bus.req_w      = '0;
    bus.req_h      = '0;
    bus.req_colour = '0;
    resetn = 1'b0;
    #2;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_plot", 32'(bus.plot), 32'd0);
    check("reset_ack", 32'(bus.ack), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    tick(3);
    resetn = 1'b1;

    // Single 2x2 fill from requester 1
    pb = plot_log.size(); db = done_id_log.size(); ab = ack_cyc_log.size();
    set_rect(1, 10, 5, 2, 2, 3);
    tick(10);
    check("t1_nplot", 32'(plot_log.size() - pb), 32'd4);
    check("t1_p0", 32'(plot_log[pb]),     32'({8'd10, 7'd5, 3'd3}));
    check("t1_p1", 32'(plot_log[pb + 1]), 32'({8'd11, 7'd5, 3'd3}));
    check("t1_p2", 32'(plot_log[pb + 2]), 32'({8'd10, 7'd6, 3'd3}));
    check("t1_p3", 32'(plot_log[pb + 3]), 32'({8'd11, 7'd6, 3'd3}));
    check("t1_ndone", 32'(done_id_log.size() - db), 32'd1);
    check("t1_done_id", 32'(done_id_log[db]), 32'd1);
    check("t1_latency", 32'(done_cyc_log[db] - ack_cyc_log[ab]), 32'd4);
    check("t1_busy_after", 32'(busy_log[done_cyc_log[db]]), 32'd0);

    // Two simultaneous 1x1 requests after reset
    do_reset();
    db = done_id_log.size(); pb = plot_log.size();
    set_rect(0, 20, 20, 1, 1, 1);
    set_rect(2, 30, 30, 1, 1, 2);
    tick(10);
    check("t2_ndone", 32'(done_id_log.size() - db), 32'd2);
    check("t2_first", 32'(done_id_log[db]), 32'd0);
    check("t2_second", 32'(done_id_log[db + 1]), 32'd2);
    check("t2_pix0", 32'(plot_log[pb]), 32'({8'd20, 7'd20, 3'd1}));

    // All four hold requests continuously
    do_reset();
    auto_drop = 1'b0;
    db = done_id_log.size();
    for (int i = 0; i < N; i++) set_rect(i, 4 * i, i, 1, 1, i);
    tick(24);
    bus.req   = '0;
    auto_drop = 1'b1;
    tick(6);
    check("t3_count_ok", 32'(done_id_log.size() - db >= 6), 32'd1);
    if (done_id_log.size() - db >= 6) begin
      for (int i = 0; i < 6; i++) check("t3_order", 32'(done_id_log[db + i]), 32'(i % N));
      for (int i = 0; i < 5; i++) check("t3_gap", 32'(done_cyc_log[db + i + 1] - done_cyc_log[db + i]), 32'd3);
    end

    // Clipping at the bottom-right corner
    pb = plot_log.size(); dc = draw_cnt;
    set_rect(2, 158, 119, 4, 2, 5);
    tick(16);
    check("t4_draw_cycles", 32'(draw_cnt - dc), 32'd8);
    check("t4_nplot", 32'(plot_log.size() - pb), 32'd2);
    check("t4_p0", 32'(plot_log[pb]),     32'({8'd158, 7'd119, 3'd5}));
    check("t4_p1", 32'(plot_log[pb + 1]), 32'({8'd159, 7'd119, 3'd5}));

    // Zero-width rectangle
    pb = plot_log.size(); db = done_id_log.size(); ab = ack_cyc_log.size();
    set_rect(3, 40, 40, 0, 5, 6);
    tick(6);
    check("t5_nplot", 32'(plot_log.size() - pb), 32'd0);
    check("t5_ndone", 32'(done_id_log.size() - db), 32'd1);
    check("t5_done_id", 32'(done_id_log[db]), 32'd3);
    check("t5_nack", 32'(ack_cyc_log.size() - ab), 32'd1);

    // Reset during pixel 3 of a 4x4 fill from requester 0
    set_rect(0, 50, 50, 4, 4, 7);
    tick(3);
    db = done_id_log.size();
    #2;
    resetn = 1'b0;
    #1;
    check("t6_plot_now", 32'(bus.plot), 32'd0);
    check("t6_busy_now", 32'(bus.busy), 32'd0);
    tick(2);
    resetn = 1'b1;
    tick(3);
    check("t6_no_done", 32'(done_id_log.size() - db), 32'd0);
    set_rect(1, 60, 60, 1, 1, 1);
    set_rect(0, 70, 70, 1, 1, 2);
    tick(10);
    check("t6_ndone", 32'(done_id_log.size() - db), 32'd2);
    check("t6_first", 32'(done_id_log[db]), 32'd0);
    check("t6_second", 32'(done_id_log[db + 1]), 32'd1);

    // Randomised traffic against the model
    auto_drop = 1'b0;
    rand_en   = 1'b1;
    tick(1500);
    rand_en   = 1'b0;
    resetn    = 1'b1;
    bus.req   = '0;
    tick(40);
    check("final_idle", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
